// File: rtl/i2c_bus_conditioner.sv
// I2C pin front end: 2-flop synchronisers, glitch filters, bus event strobes and bit/byte tracking.
// Optional stuck-bus timeout is built only when I2C_COND_TIMEOUT_EN is defined.
module i2c_bus_conditioner #(
    parameter int FILTER_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       scl_filt,
    output logic       sda_filt,
    output logic       scl_rise,
    output logic       scl_fall,
    output logic       start_det,
    output logic       stop_det,
    output logic       bus_busy,
    output logic [3:0] bit_cnt,
    output logic [7:0] rx_byte,
    output logic       ack_bit,
    output logic       byte_done,
    output logic       first_byte,
    output logic       timeout
);
    localparam int CW = $clog2(FILTER_CYCLES + 1);

    if (FILTER_CYCLES < 1 || FILTER_CYCLES > 255) begin : g_bad_filter
        $error("FILTER_CYCLES out of range 1..255");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 1048576) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES out of range 1..2^20");
    end

    typedef enum logic {IDLE, ACTIVE} state_t;
    state_t state_reg, state_next;

    logic [1:0] pin_vec, filt_vec;
    assign pin_vec = {scl_in, sda_in};

    // Index 1 is SCL, index 0 is SDA; both lines share the same sync + filter structure.
    for (genvar gi = 0; gi < 2; gi++) begin : g_line
        logic          sync1_reg, sync2_reg, filt_reg;
        logic [CW-1:0] cnt_reg;
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                sync1_reg <= 1'b1;
                sync2_reg <= 1'b1;
                filt_reg  <= 1'b1;
                cnt_reg   <= '0;
            end else begin
                sync1_reg <= pin_vec[gi];
                sync2_reg <= sync1_reg;
                if (sync2_reg == filt_reg) begin
                    cnt_reg <= '0;
                end else if (cnt_reg == CW'(FILTER_CYCLES - 1)) begin
                    filt_reg <= sync2_reg;
                    cnt_reg  <= '0;
                end else begin
                    cnt_reg <= cnt_reg + CW'(1);
                end
            end
        end
        assign filt_vec[gi] = filt_reg;
    end

    assign scl_filt = filt_vec[1];
    assign sda_filt = filt_vec[0];

    logic scl_prev_reg, sda_prev_reg;
    logic rise_c, fall_c, start_c, stop_c, timeout_c;

    // SDA may only count as START/STOP when SCL was high and stayed high.
    assign rise_c  = !scl_prev_reg && scl_filt;
    assign fall_c  = scl_prev_reg && !scl_filt;
    assign start_c = scl_prev_reg && scl_filt && sda_prev_reg && !sda_filt;
    assign stop_c  = scl_prev_reg && scl_filt && !sda_prev_reg && sda_filt;

`ifdef I2C_COND_TIMEOUT_EN
    logic [19:0] to_cnt_reg;
    assign timeout_c = (state_reg == ACTIVE) && !scl_filt && !start_c && !stop_c &&
                       (to_cnt_reg == 20'(TIMEOUT_CYCLES - 1));
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt_reg <= '0;
        end else if (state_reg == IDLE || scl_filt || timeout_c) begin
            to_cnt_reg <= '0;
        end else begin
            to_cnt_reg <= to_cnt_reg + 20'd1;
        end
    end
`else
    assign timeout_c = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start_c) state_next = ACTIVE;
            ACTIVE:  if (stop_c || timeout_c) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    logic       scl_rise_reg, scl_fall_reg, start_det_reg, stop_det_reg, timeout_reg;
    logic       ack_bit_reg, byte_done_reg, first_byte_reg;
    logic [3:0] bit_cnt_reg;
    logic [7:0] shift_reg, rx_byte_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_prev_reg   <= 1'b1;
            sda_prev_reg   <= 1'b1;
            scl_rise_reg   <= 1'b0;
            scl_fall_reg   <= 1'b0;
            start_det_reg  <= 1'b0;
            stop_det_reg   <= 1'b0;
            timeout_reg    <= 1'b0;
            ack_bit_reg    <= 1'b0;
            byte_done_reg  <= 1'b0;
            first_byte_reg <= 1'b0;
            bit_cnt_reg    <= 4'd0;
            shift_reg      <= 8'h00;
            rx_byte_reg    <= 8'h00;
        end else begin
            scl_prev_reg  <= scl_filt;
            sda_prev_reg  <= sda_filt;
            scl_rise_reg  <= rise_c;
            scl_fall_reg  <= fall_c;
            start_det_reg <= start_c;
            stop_det_reg  <= stop_c;
            timeout_reg   <= timeout_c;
            byte_done_reg <= 1'b0;
            if (start_c) begin
                bit_cnt_reg    <= 4'd0;
                shift_reg      <= 8'h00;
                first_byte_reg <= 1'b1;
            end else if (stop_c || timeout_c) begin
                // Partial byte is discarded; rx_byte keeps the last complete one.
                bit_cnt_reg    <= 4'd0;
                shift_reg      <= 8'h00;
                first_byte_reg <= 1'b0;
            end else if (rise_c && state_reg == ACTIVE) begin
                if (bit_cnt_reg == 4'd8) begin
                    rx_byte_reg    <= shift_reg;
                    ack_bit_reg    <= sda_filt;
                    byte_done_reg  <= 1'b1;
                    bit_cnt_reg    <= 4'd0;
                    first_byte_reg <= 1'b0;
                end else begin
                    shift_reg   <= {shift_reg[6:0], sda_filt};
                    bit_cnt_reg <= bit_cnt_reg + 4'd1;
                end
            end
        end
    end

    assign scl_rise   = scl_rise_reg;
    assign scl_fall   = scl_fall_reg;
    assign start_det  = start_det_reg;
    assign stop_det   = stop_det_reg;
    assign bus_busy   = (state_reg == ACTIVE);
    assign bit_cnt    = bit_cnt_reg;
    assign rx_byte    = rx_byte_reg;
    assign ack_bit    = ack_bit_reg;
    assign byte_done  = byte_done_reg;
    assign first_byte = first_byte_reg;
    assign timeout    = timeout_reg;
endmodule

// File: tb/tb_i2c_bus_conditioner.sv
// Bench for i2c_bus_conditioner: directed scenarios plus randomized I2C traffic and pin noise,
// checked every cycle against a behavioural model of filtered lines, bus events and received bytes.
module tb_i2c_bus_conditioner;
    localparam int F = 4;
`ifdef I2C_COND_TIMEOUT_EN
    localparam int TO = 100;
`else
    localparam int TO = 65535;
`endif

    logic       clk = 1'b0;
    logic       rst, scl_in, sda_in;
    logic       scl_filt, sda_filt, scl_rise, scl_fall, start_det, stop_det, bus_busy;
    logic [3:0] bit_cnt;
    logic [7:0] rx_byte;
    logic       ack_bit, byte_done, first_byte, timeout;

    always #5 clk = ~clk;

    i2c_bus_conditioner #(.FILTER_CYCLES(F), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .scl_in(scl_in), .sda_in(sda_in),
        .scl_filt(scl_filt), .sda_filt(sda_filt), .scl_rise(scl_rise), .scl_fall(scl_fall),
        .start_det(start_det), .stop_det(stop_det), .bus_busy(bus_busy), .bit_cnt(bit_cnt),
        .rx_byte(rx_byte), .ack_bit(ack_bit), .byte_done(byte_done), .first_byte(first_byte),
        .timeout(timeout)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    // Behavioural model: raw pin history (index 0 = pin seen at previous edge), filtered lines,
    // and the bus view as a list of bits received since the last byte boundary.
    bit       hist_scl [F+2];
    bit       hist_sda [F+2];
    bit       f_scl, f_sda, p_scl, p_sda;
    bit       m_busy, m_first, m_ack;
    bit       e_rise, e_fall, e_start, e_stop, e_done, e_to;
    bit       bits[$];
    logic [7:0] m_rx;
    int       low_run;

    // A line flips once the synchronised copy has shown the other level for F straight samples.
    function automatic bit win_next(input bit h [F+2], input bit f);
        for (int i = 1; i <= F; i++) begin
            if (h[i] == f) return f;
        end
        return !f;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < F + 2; i++) begin
            hist_scl[i] = 1'b1;
            hist_sda[i] = 1'b1;
        end
        f_scl = 1; f_sda = 1; p_scl = 1; p_sda = 1;
        m_busy = 0; m_first = 0; m_ack = 0; m_rx = 8'h00; low_run = 0;
        e_rise = 0; e_fall = 0; e_start = 0; e_stop = 0; e_done = 0; e_to = 0;
        bits.delete();
    endtask

    task automatic model_step(input bit pscl, input bit psda);
        bit nf_scl, nf_sda;
        e_rise  = !p_scl && f_scl;
        e_fall  = p_scl && !f_scl;
        e_start = p_scl && f_scl && p_sda && !f_sda;
        e_stop  = p_scl && f_scl && !p_sda && f_sda;
        e_done  = 0;
        e_to    = 0;
`ifdef I2C_COND_TIMEOUT_EN
        if (m_busy && !f_scl) begin
            low_run++;
            if (low_run == TO && !e_start && !e_stop) begin
                e_to = 1;
                low_run = 0;
            end
        end else begin
            low_run = 0;
        end
`endif
        if (e_start) begin
            m_busy = 1; m_first = 1; bits.delete();
        end else if (e_stop || e_to) begin
            m_busy = 0; m_first = 0; bits.delete();
        end else if (e_rise && m_busy) begin
            if (bits.size() < 8) begin
                bits.push_back(f_sda);
            end else begin
                for (int i = 0; i < 8; i++) m_rx[7-i] = bits[i];
                m_ack = f_sda; e_done = 1; m_first = 0;
                bits.delete();
            end
        end
        nf_scl = win_next(hist_scl, f_scl);
        nf_sda = win_next(hist_sda, f_sda);
        p_scl = f_scl; p_sda = f_sda;
        f_scl = nf_scl; f_sda = nf_sda;
        for (int i = F + 1; i > 0; i--) begin
            hist_scl[i] = hist_scl[i-1];
            hist_sda[i] = hist_sda[i-1];
        end
        hist_scl[0] = pscl;
        hist_sda[0] = psda;
    endtask

    // Event log used by the directed scenarios.
    int   start_cnt = 0, stop_cnt = 0, done_cnt = 0, to_cnt = 0, pulse_cnt = 0;
    int   last_start_cyc = 0, sfall_cyc = 0, to_cyc = 0;
    bit   sda_low_seen = 0, prev_first = 0, prev_scl_mon = 1;
    logic [7:0] bd_rx = 8'h00;
    bit   bd_ack = 0, bd_first_before = 0, bd_first_after = 0;

    always @(posedge clk) begin
        cyc++;
        if (rst) model_reset();
        else     model_step(scl_in, sda_in);
        #1;
        chk("scl_filt",   8'(scl_filt),   8'(f_scl));
        chk("sda_filt",   8'(sda_filt),   8'(f_sda));
        chk("scl_rise",   8'(scl_rise),   8'(e_rise));
        chk("scl_fall",   8'(scl_fall),   8'(e_fall));
        chk("start_det",  8'(start_det),  8'(e_start));
        chk("stop_det",   8'(stop_det),   8'(e_stop));
        chk("bus_busy",   8'(bus_busy),   8'(m_busy));
        chk("bit_cnt",    8'(bit_cnt),    8'(bits.size()));
        chk("rx_byte",    rx_byte,        m_rx);
        chk("ack_bit",    8'(ack_bit),    8'(m_ack));
        chk("byte_done",  8'(byte_done),  8'(e_done));
        chk("first_byte", 8'(first_byte), 8'(m_first));
        chk("timeout",    8'(timeout),    8'(e_to));
        if (start_det) begin start_cnt++; last_start_cyc = cyc; end
        if (stop_det) stop_cnt++;
        if (timeout) begin to_cnt++; to_cyc = cyc; end
        if (byte_done) begin
            done_cnt++; bd_rx = rx_byte; bd_ack = ack_bit;
            bd_first_before = prev_first; bd_first_after = first_byte;
        end
        if (scl_rise || scl_fall || start_det || stop_det || byte_done || timeout) pulse_cnt++;
        if (!sda_filt) sda_low_seen = 1;
        if (prev_scl_mon && !scl_filt) sfall_cyc = cyc;
        prev_scl_mon = scl_filt;
        prev_first = first_byte;
    end

    int H = 8;
    bit glitch_en = 0;

    task automatic hold(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start();
        sda_in = 1; hold(H);
        scl_in = 1; hold(H);
        sda_in = 0; hold(H);
        scl_in = 0; hold(H);
    endtask

    task automatic i2c_bit(input bit b);
        sda_in = b; hold(H);
        scl_in = 1; hold(H / 2);
        if (glitch_en && $urandom_range(0, 2) == 0) begin
            sda_in = !b; hold($urandom_range(1, F - 1));
            sda_in = b;
        end
        hold(H - H / 2);
        scl_in = 0; hold(H);
    endtask

    task automatic i2c_byte(input logic [7:0] v, input bit a);
        for (int i = 7; i >= 0; i--) i2c_bit(v[i]);
        i2c_bit(a);
    endtask

    task automatic i2c_stop();
        sda_in = 0; hold(H);
        scl_in = 1; hold(H);
        sda_in = 1; hold(H);
    endtask

    int s0, c0, d0, p0;
    bit stopped;

    initial begin
        rst = 1; scl_in = 1; sda_in = 1;
        hold(3);
        chk("rst_scl_filt", 8'(scl_filt), 8'd1);
        chk("rst_busy",     8'(bus_busy), 8'd0);
        chk("rst_bit_cnt",  8'(bit_cnt),  8'd0);
        chk("rst_rx_byte",  rx_byte,      8'h00);
        rst = 0;
        p0 = pulse_cnt;
        hold(20);
        chk("idle_pulses", 8'(pulse_cnt - p0), 8'd0);

        // Short SDA glitch under SCL high must vanish; a long one is a START.
        s0 = start_cnt; sda_low_seen = 0;
        sda_in = 0; hold(3); sda_in = 1; hold(20);
        chk("glitch_sda_low", 8'(sda_low_seen),      8'd0);
        chk("glitch_start",   8'(start_cnt - s0),    8'd0);
        c0 = cyc;
        sda_in = 0; hold(5); sda_in = 1; hold(20);
        chk("start_count",    8'(start_cnt - s0),    8'd1);
        chk("start_latency",  8'(last_start_cyc - c0), 8'd7);

        // Address byte 0x90 with ACK.
        d0 = done_cnt;
        i2c_start();
        i2c_byte(8'h90, 1'b0);
        chk("addr_done_cnt", 8'(done_cnt - d0), 8'd1);
        chk("addr_rx",       bd_rx,              8'h90);
        chk("addr_ack",      8'(bd_ack),         8'd0);
        chk("addr_first_hi", 8'(bd_first_before), 8'd1);
        chk("addr_first_lo", 8'(bd_first_after),  8'd0);

        // Repeated START after five bits, then a full byte 0x91 with NACK.
        for (int i = 0; i < 5; i++) i2c_bit(1'(i % 2));
        s0 = start_cnt;
        i2c_start();
        chk("rs_start",   8'(start_cnt - s0), 8'd1);
        chk("rs_bit_cnt", 8'(bit_cnt),        8'd0);
        chk("rs_busy",    8'(bus_busy),       8'd1);
        chk("rs_first",   8'(first_byte),     8'd1);
        i2c_byte(8'h91, 1'b1);
        chk("rs_rx",  bd_rx,          8'h91);
        chk("rs_ack", 8'(bd_ack),     8'd1);

        // STOP after three bits drops the partial byte; later SCL rises are ignored.
        for (int i = 0; i < 3; i++) i2c_bit(1'b0);
        s0 = stop_cnt;
        i2c_stop();
        chk("stop_cnt",  8'(stop_cnt - s0), 8'd1);
        chk("stop_busy", 8'(bus_busy),      8'd0);
        chk("stop_rx",   rx_byte,           8'h91);
        scl_in = 0; hold(H); scl_in = 1; hold(H);
        chk("idle_bit_cnt", 8'(bit_cnt), 8'd0);

        // Stuck SCL low while busy.
        c0 = to_cnt;
        i2c_start();
        hold(150);
`ifdef I2C_COND_TIMEOUT_EN
        chk("to_count",   8'(to_cnt - c0),        8'd1);
        chk("to_latency", 8'(to_cyc - sfall_cyc), 8'd100);
        chk("to_busy",    8'(bus_busy),           8'd0);
`else
        chk("to_count",   8'(to_cnt - c0),        8'd0);
        chk("to_busy",    8'(bus_busy),           8'd1);
`endif
        i2c_stop();

        // Reset in the middle of a byte; a lone SCL rise afterwards must not count.
        i2c_start();
        for (int i = 0; i < 4; i++) i2c_bit(1'b1);
        rst = 1; hold(2);
        chk("midrst_busy", 8'(bus_busy), 8'd0);
        chk("midrst_cnt",  8'(bit_cnt),  8'd0);
        rst = 0; scl_in = 1; sda_in = 1; hold(20);
        scl_in = 0; hold(10); scl_in = 1; hold(10);
        chk("midrst_idle_cnt", 8'(bit_cnt), 8'd0);

        // Randomized traffic with glitches, repeated STARTs, aborted bytes and raw noise.
        glitch_en = 1;
        for (int t = 0; t < 20; t++) begin
            H = $urandom_range(F + 2, 10);
            stopped = 0;
            i2c_start();
            for (int b = 0; b < $urandom_range(1, 3) && !stopped; b++) begin
                case ($urandom_range(0, 5))
                    0: begin
                        for (int k = 0; k < $urandom_range(0, 8); k++) i2c_bit(1'($urandom_range(0, 1)));
                        i2c_start();
                    end
                    1: begin
                        for (int k = 0; k < $urandom_range(1, 7); k++) i2c_bit(1'($urandom_range(0, 1)));
                        i2c_stop();
                        stopped = 1;
                    end
                    default: i2c_byte(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
                endcase
            end
            if (!stopped) i2c_stop();
            if (t % 5 == 4) begin
                for (int k = 0; k < 60; k++) begin
                    scl_in = 1'($urandom_range(0, 1));
                    sda_in = 1'($urandom_range(0, 1));
                    hold($urandom_range(1, 7));
                end
                scl_in = 1; sda_in = 1; hold(20);
            end
        end
        hold(10);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/i2c_bus_conditioner.md
# i2c_bus_conditioner

Input front end placed directly upstream of the I2C address translator. Synchronises the raw SCL/SDA pins into the `clk` domain and glitch-filters them. Detects bus events (SCL edges, START, repeated START, STOP) and tracks bit and byte boundaries. The translator consumes these clean lines and single-cycle event strobes instead of sampling asynchronous pins itself.

## Interface
Parameters:
- `FILTER_CYCLES`, 4: consecutive stable clocks required before a filtered line changes; legal range 1..255.
- `TIMEOUT_CYCLES`, 65535: SCL-low clocks, while busy, that count as a stuck bus; used only with the macro. Legal range 1..2^20.

Ports:
- `clk`  in  1: system clock; all logic is on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `scl_in`  in  1: raw SCL pin, asynchronous.
- `sda_in`  in  1: raw SDA pin, asynchronous.
- `scl_filt`  out  1: synchronised, filtered SCL.
- `sda_filt`  out  1: synchronised, filtered SDA.
- `scl_rise` / `scl_fall`  out  1: one-cycle pulses on `scl_filt` edges.
- `start_det`  out  1: one-cycle pulse on START or repeated START.
- `stop_det`  out  1: one-cycle pulse on STOP.
- `bus_busy`  out  1: high from START until STOP (or timeout).
- `bit_cnt`  out  4: bit position in the current byte, 0..8; 8 is the ACK slot.
- `rx_byte`  out  8: last completed byte, MSB first.
- `ack_bit`  out  1: SDA sampled at the ACK-slot rise; 0 means ACK.
- `byte_done`  out  1: one-cycle pulse when the ACK slot is sampled.
- `first_byte`  out  1: high while the byte in progress is the first one after a START (the address byte).
- `timeout`  out  1: one-cycle stuck-bus pulse; tied 0 without the macro.

## Operation
- Synchroniser: two flops per line, both reset to 1.
- Filter, per line:
  - Counter width is `$clog2(FILTER_CYCLES+1)`.
  - The counter clears whenever the synchronised value equals the filtered value.
  - Otherwise it increments. When it reaches `FILTER_CYCLES`, the filtered value toggles and the counter clears.
  - Pulses shorter than `FILTER_CYCLES` clocks are dropped entirely.
- Edge and event detection compares the current filtered values with a registered previous copy:
  - `scl_rise` = prev 0, now 1. `scl_fall` = prev 1, now 0.
  - START: SDA falls while SCL is 1 both in the previous and the current cycle. STOP: SDA rises under the same SCL condition.
  - If SCL and SDA change in the same cycle, no START/STOP is flagged; it is treated as a data transition.
- State machine with states IDLE and ACTIVE:
  - IDLE → ACTIVE on START.
  - ACTIVE → IDLE on STOP or timeout.
  - ACTIVE → ACTIVE on a repeated START: `bit_cnt` cleared, shift register cleared, `first_byte` set.
  - `bus_busy` is 1 exactly when the state is ACTIVE.
- Bit tracking applies on `scl_rise` in ACTIVE only; rises in IDLE are ignored.
  - If `bit_cnt` < 8: shift `sda_filt` into the shift register, then `bit_cnt`+1.
  - If `bit_cnt` == 8: `rx_byte` ← shift register, `ack_bit` ← `sda_filt`, pulse `byte_done`, `bit_cnt` ← 0, clear `first_byte`.
- A STOP in mid-byte drops the partial byte. `rx_byte` keeps its previous value.

## Timing
- Reset values:
  - `scl_filt`, `sda_filt` = 1.
  - `bus_busy`, `first_byte`, `ack_bit`, `timeout` and all pulse outputs = 0.
  - `bit_cnt` = 0, `rx_byte` = 8'h00.
  - State = IDLE.
- Reset mid-transfer returns everything to these values immediately. The next transfer requires a fresh START.
- Pin-to-filtered latency: 2 + `FILTER_CYCLES` clocks.
- Filtered-to-event latency: 1 clock. Every event output and `bit_cnt` is registered.
- Pulse outputs are high for exactly one clock.
- Pulse coincidences:
  - `byte_done` coincides with that cycle's `scl_rise`.
  - `start_det` and `stop_det` can never both be high in the same cycle.
- Event vs. timeout priority: START/STOP take priority over a timeout expiring in the same cycle.

## Configuration
- Macro `I2C_COND_TIMEOUT_EN`.
- Defined: a 20-bit counter increments every clock while ACTIVE and `scl_filt`==0.
  - It clears when SCL is high or the state is IDLE.
  - On reaching `TIMEOUT_CYCLES`: pulse `timeout`, go to IDLE, clear `bit_cnt`, clear the counter.
- Undefined: no counter is built, `timeout` is held 0, and the bus stays ACTIVE until a STOP.

## Test plan
All scenarios use `FILTER_CYCLES`=4 and a 10 ns clock.
1. Reset: assert `rst` with both pins at 1 → all outputs at their reset values. Release `rst` and hold the pins for 20 clocks → no pulses.
2. Glitch: 3-clock low pulse on `sda_in` with SCL high → `sda_filt` stays 1 and no `start_det`. A 5-clock low pulse → `start_det` fires 7 clocks after the pin falls.
3. Address byte: START, then send 0x90 (address 0x48, write) and ACK=0 → one `byte_done`; `rx_byte`=8'h90, `ack_bit`=0, `first_byte` 1→0 in that cycle.
4. Repeated START after 5 bits → `start_det` pulses, `bit_cnt`=0, `bus_busy` stays 1, `first_byte`=1. Next full byte 0x91 → `rx_byte`=8'h91.
5. STOP mid-byte after 3 bits → `stop_det` pulses, `bus_busy`=0, `rx_byte` unchanged. Then SCL rises with no START → `bit_cnt` stays 0.
6. With `I2C_COND_TIMEOUT_EN` and `TIMEOUT_CYCLES`=100: START, then hold SCL low → `timeout` pulses once, 100 clocks after `scl_filt` falls; `bus_busy`=0. Without the macro → `timeout` stays 0 and `bus_busy` stays 1.
